// File: rtl/i2s_tx_dsp_frame_ctrl.sv
// Frame sequencer for the I2S TX channel in DSP master mode: arms the channel, emits the
// one-cycle frame-sync, tracks word/slot boundaries, stops on frame edges, flags underruns.
module i2s_tx_dsp_frame_ctrl #(
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   sck_i,
  input  logic                   rstn_i,
  input  logic                   cfg_en_i,
  input  logic [4:0]             cfg_num_bits_i,
  input  logic [3:0]             cfg_num_word_i,
  input  logic [8:0]             cfg_frame_len_i,
  input  logic                   cfg_clr_err_i,
  input  logic                   master_ready_to_send_i,
  input  logic                   fifo_data_valid_i,
  input  logic                   fifo_data_ready_i,
  output logic                   tx_en_o,
  output logic                   ws_o,
  output logic                   word_start_o,
  output logic [3:0]             slot_o,
  output logic                   busy_o,
  output logic                   underrun_o,
  output logic                   err_underrun_o,
  output logic                   err_cfg_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, STOP} state_t;

  // Shortest frame that still holds every word: words*bits-1, at most 511.
  function automatic logic [9:0] calc_min_len(input logic [4:0] bits, input logic [3:0] words);
    logic [9:0] prod;
    prod = ({6'd0, words} + 10'd1) * ({5'd0, bits} + 10'd1);
    return prod - 10'd1;
  endfunction

  function automatic logic [8:0] calc_len_eff(input logic [8:0] flen, input logic [9:0] min_len);
    if ({1'b0, flen} < min_len) return min_len[8:0];
    return flen;
  endfunction

  state_t     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [4:0] wbit_q, wbit_d;
  logic [3:0] slot_q, slot_d;
  logic [4:0] bits_l;
  logic [3:0] words_l;
  logic [8:0] len_l;

  logic [9:0] min_len_c;
  logic [8:0] len_eff_c;
  logic       cfg_short_c;
  logic       latch;
  logic       frame_end;
  logic       wstart_d;
  logic       underrun_c;

  assign min_len_c   = calc_min_len(cfg_num_bits_i, cfg_num_word_i);
  assign len_eff_c   = calc_len_eff(cfg_frame_len_i, min_len_c);
  assign cfg_short_c = ({1'b0, cfg_frame_len_i} < min_len_c);
  assign underrun_c  = fifo_data_ready_i && !fifo_data_valid_i &&
                       ((state_q == RUN) || (state_q == STOP));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wbit_d    = wbit_q;
    slot_d    = slot_q;
    latch     = 1'b0;
    frame_end = 1'b0;
    wstart_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        wbit_d = '0;
        slot_d = '0;
        if (cfg_en_i) state_d = ARM;
      end
      ARM: begin
        cnt_d  = '0;
        wbit_d = '0;
        slot_d = '0;
        if (!cfg_en_i) begin
          state_d = IDLE;
        end else if (master_ready_to_send_i) begin
          state_d  = RUN;
          latch    = 1'b1;
          wstart_d = 1'b1;
        end
      end
      RUN, STOP: begin
        // RUN and STOP count identically; only the frame edge decides whether to go on.
        frame_end = (cnt_q == len_l);
        if (frame_end) begin
          cnt_d    = '0;
          wbit_d   = '0;
          slot_d   = '0;
          state_d  = cfg_en_i ? RUN : IDLE;
          latch    = cfg_en_i;
          wstart_d = cfg_en_i;
        end else begin
          cnt_d   = cnt_q + 9'd1;
          state_d = cfg_en_i ? RUN : STOP;
          if (wbit_q != bits_l) begin
            wbit_d = wbit_q + 5'd1;
          end else if (slot_q < words_l) begin
            wbit_d   = '0;
            slot_d   = slot_q + 4'd1;
            wstart_d = 1'b1;
          end
          // Past the last word the slot holds through the padding cycles.
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sck_i) begin
    if (!rstn_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      wbit_q         <= '0;
      slot_q         <= '0;
      tx_en_o        <= 1'b0;
      busy_o         <= 1'b0;
      ws_o           <= 1'b0;
      word_start_o   <= 1'b0;
      slot_o         <= '0;
      frame_cnt_o    <= '0;
      underrun_o     <= 1'b0;
      err_underrun_o <= 1'b0;
      err_cfg_o      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wbit_q         <= wbit_d;
      slot_q         <= slot_d;
      tx_en_o        <= (state_d != IDLE);
      busy_o         <= (state_d != IDLE);
      ws_o           <= latch;
      word_start_o   <= wstart_d;
      slot_o         <= slot_d;
      if (frame_end) frame_cnt_o <= frame_cnt_o + FRAME_CNT_W'(1);
      underrun_o     <= underrun_c;
      // A new error wins over a simultaneous clear.
      err_underrun_o <= underrun_c | (err_underrun_o & ~cfg_clr_err_i);
      err_cfg_o      <= (latch & cfg_short_c) | (err_cfg_o & ~cfg_clr_err_i);
    end
  end

  // Frame geometry is data only: captured at frame start, never read before its first capture.
  always_ff @(posedge sck_i) begin
    if (latch) begin
      bits_l  <= cfg_num_bits_i;
      words_l <= cfg_num_word_i;
      len_l   <= len_eff_c;
    end
  end

endmodule
